// File: rtl/aes_block_feeder_if.sv
// ---------------------------------------------------------------------------
// aes_block_feeder_if
//   Bundles the stream, key and core-side signals of aes_block_feeder.
//   Handshake: a block transfers on a rising edge where in_valid && in_ready.
//   in_valid is not withdrawn by the feeder; in_ready depends only on FIFO
//   occupancy (and reset). out_valid has no ready: every pulse must be taken.
//
//   Modports
//     slave  : the feeder itself (consumes in_*, key_*, pause, aes_out)
//     master : the environment (producer, key source, AES core, consumer)
//
//   Signals
//     in_valid/in_ready/in_data : plaintext block stream
//     key_load/key_in/key_err   : key load request and rejection pulse
//     pause                     : suppress issue for one cycle
//     aes_data/aes_key/aes_issue: registered drive into the AES core
//     aes_out                   : ciphertext from the AES core
//     out_valid/out_data/out_tag: registered result with sequence tag
//     count/in_flight           : FIFO occupancy, blocks inside the core path
// ---------------------------------------------------------------------------
interface aes_block_feeder_if #(
    parameter int DEPTH    = 16,
    parameter int PIPE_LAT = 11,
    parameter int TAG_W    = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int INF_W = $clog2(PIPE_LAT + 1) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic             key_load;
    logic [127:0]     key_in;
    logic             key_err;
    logic             pause;
    logic [127:0]     aes_data;
    logic [127:0]     aes_key;
    logic             aes_issue;
    logic [127:0]     aes_out;
    logic             out_valid;
    logic [127:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] count;
    logic [INF_W-1:0] in_flight;

    modport slave (
        input  in_valid, in_data, key_load, key_in, pause, aes_out,
        output in_ready, key_err, aes_data, aes_key, aes_issue,
               out_valid, out_data, out_tag, count, in_flight
    );

    modport master (
        output in_valid, in_data, key_load, key_in, pause, aes_out,
        input  in_ready, key_err, aes_data, aes_key, aes_issue,
               out_valid, out_data, out_tag, count, in_flight
    );
endinterface

// File: rtl/aes_block_feeder.sv
// ---------------------------------------------------------------------------
// aes_block_feeder
//   Front/back end for a fully pipelined AES-128 encrypt core. Plaintext
//   blocks are buffered in a FIFO, issued at most one per clock into the core,
//   tracked through a valid/tag shift register matching the core latency, and
//   the ciphertext is registered with a sequence tag. The key register may
//   only change while the whole path is empty.
//
//   Ports
//     clk   : clock, rising edge
//     reset : synchronous, active-low; clears all state
//     bus   : aes_block_feeder_if.slave (stream, key, core and status signals)
// ---------------------------------------------------------------------------
module aes_block_feeder #(
    parameter int DEPTH    = 16,
    parameter int PIPE_LAT = 11,
    parameter int TAG_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    aes_block_feeder_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int INF_W = $clog2(PIPE_LAT + 1) + 1;

    // FIFO storage and bookkeeping
    logic [127:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Core drive
    logic [127:0]     r_aes_data;
    logic [127:0]     r_aes_key;
    logic             r_aes_issue;
    logic [TAG_W-1:0] r_tag_ctr;
    logic [TAG_W-1:0] r_issue_tag;

    // Valid/tag tracker following each block through the core
    logic [PIPE_LAT-1:0] r_sr_vld;
    logic [TAG_W-1:0]    r_sr_tag [PIPE_LAT];
    logic [INF_W-1:0]    r_in_flight;

    // Result and status
    logic             r_out_valid;
    logic [127:0]     r_out_data;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_key_err;

    logic w_in_ready;
    logic w_push;
    logic w_issue;
    logic w_retire;
    logic w_key_ok;

    // in_ready is held low while reset is asserted.
    assign w_in_ready = reset && (r_count != CNT_W'(DEPTH));
    assign w_push     = bus.in_valid && w_in_ready;
    // Issue reads only registered occupancy, so a block pushed this cycle
    // cannot be issued before the next one.
    assign w_issue    = (r_count != '0) && !bus.pause;
    // The last tracker stage lines up with the core presenting that block's
    // ciphertext on aes_out.
    assign w_retire   = r_sr_vld[PIPE_LAT-1];
    // A key change is safe only when nothing is buffered, in the core, or
    // about to enter the FIFO.
    assign w_key_ok   = (r_count == '0) && (r_in_flight == '0) && !r_aes_issue && !w_push;

    // FIFO storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_aes_data  <= '0;
            r_aes_key   <= '0;
            r_aes_issue <= 1'b0;
            r_tag_ctr   <= '0;
            r_issue_tag <= '0;
            r_sr_vld    <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_sr_tag[i] <= '0;
            end
            r_in_flight <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_key_err   <= 1'b0;
        end else begin
            // FIFO pointers wrap naturally because DEPTH is a power of two.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // Core drive: zero data on bubbles so idle cycles are clean.
            r_aes_issue <= w_issue;
            r_aes_data  <= w_issue ? r_mem[r_rd_ptr] : '0;
            r_issue_tag <= r_tag_ctr;
            if (w_issue) begin
                r_tag_ctr <= r_tag_ctr + TAG_W'(1);
            end

            // Tracker: stage 0 follows the aes_issue register by one cycle.
            r_sr_vld[0] <= r_aes_issue;
            r_sr_tag[0] <= r_issue_tag;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_sr_vld[i] <= r_sr_vld[i-1];
                r_sr_tag[i] <= r_sr_tag[i-1];
            end

            // Result register: data/tag hold between pulses.
            r_out_valid <= w_retire;
            if (w_retire) begin
                r_out_data <= bus.aes_out;
                r_out_tag  <= r_sr_tag[PIPE_LAT-1];
            end

            case ({w_issue, w_retire})
                2'b10:   r_in_flight <= r_in_flight + INF_W'(1);
                2'b01:   r_in_flight <= r_in_flight - INF_W'(1);
                default: r_in_flight <= r_in_flight;
            endcase

            if (bus.key_load && w_key_ok) begin
                r_aes_key <= bus.key_in;
            end
            r_key_err <= bus.key_load && !w_key_ok;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.key_err   = r_key_err;
    assign bus.aes_data  = r_aes_data;
    assign bus.aes_key   = r_aes_key;
    assign bus.aes_issue = r_aes_issue;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_tag   = r_out_tag;
    assign bus.count     = r_count;
    assign bus.in_flight = r_in_flight;
endmodule

// File: doc/aes_block_feeder.md
Name: aes_block_feeder

Overview:
- Stream front/back end for the pipelined AES-128 encrypt core.
- Accepts plaintext blocks over valid/ready and buffers them in a FIFO.
- Issues at most one block per clock into the core, with no stalls inside the core.
- Tracks every issued block through a valid/tag shift register of the core's latency, then registers the ciphertext with out_valid and a sequence tag.
- Holds the core key register; key changes are allowed only when the path is idle.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2.
PIPE_LAT, 11, cycles from aes_data presented to matching aes_out valid at core output.
TAG_W, 8, width of sequence tag.

Ports:
clk  input  1  clock, all logic on rising edge.
reset  input  1  synchronous, active-low.
in_valid  input  1  upstream block valid.
in_ready  output  1  FIFO can accept (not full).
in_data  input  128  plaintext block.
key_load  input  1  request to load key_in.
key_in  input  128  new cipher key.
key_err  output  1  one-cycle pulse: key_load rejected.
pause  input  1  suppress issue this cycle (bubble).
aes_data  output  128  plaintext to core, registered.
aes_key  output  128  key to core, registered.
aes_issue  output  1  aes_data carries a real block this cycle.
aes_out  input  128  ciphertext from core.
out_valid  output  1  out_data/out_tag valid, one-cycle pulse per block.
out_data  output  128  registered ciphertext.
out_tag  output  TAG_W  sequence number of the block in out_data.
count  output  clog2(DEPTH)+1  FIFO occupancy.
in_flight  output  clog2(PIPE_LAT+1)+1  blocks issued whose result has not yet appeared on out_valid.

Behaviour:
- Reset (reset==0 at posedge) clears all of the following; reset wins over every other event:
  - FIFO pointers, count=0, in_ready=0 during reset then 1.
  - aes_data=0, aes_key=0, aes_issue=0, shift register, tag counter=0, in_flight=0.
  - out_valid=0, out_data=0, out_tag=0, key_err=0.
- Reset mid-operation discards buffered and in-flight blocks; no out_valid follows from pre-reset issues.
- FIFO push: when in_valid && in_ready. in_ready = (count != DEPTH).
- No bypass: a block pushed into an empty FIFO is issued no earlier than the next cycle.
- Push and pop in the same cycle leaves count unchanged. Pointers wrap modulo DEPTH.
- Issue:
  - Condition: count != 0 && !pause.
  - Pops the head. At the next edge: aes_data = head, aes_issue = 1.
  - Otherwise aes_data = 0, aes_issue = 0.
  - Back-to-back issue every cycle while non-empty.
- Tag:
  - Counter increments on each issue and wraps from 2^TAG_W-1 to 0.
  - The tag is shifted alongside aes_issue through a PIPE_LAT-deep valid/tag shift register.
- Output:
  - When the shift register's last stage is valid, aes_out is sampled: out_data = aes_out, out_tag = tag, out_valid = 1 at the next edge.
  - Total latency: aes_issue high at cycle N gives out_valid high at cycle N+PIPE_LAT+1.
  - Otherwise out_valid = 0 and out_data/out_tag hold their last values.
- in_flight: +1 on issue, -1 on out_valid, unchanged when both occur together. Maximum value is PIPE_LAT+1.
- Key load:
  - Accepted only when count==0, in_flight==0, aes_issue==0 and no push this cycle. Then aes_key = key_in at the next edge.
  - Otherwise the request is ignored and key_err pulses 1 for the next cycle.
  - A key_load in the same cycle as an accepted push is rejected.
- No backpressure from the output side. The consumer must take every out_valid pulse.

Test Plan:
- Basic vector: key 000102030405060708090a0b0c0d0e0f, then one block 00112233445566778899aabbccddeeff.
  - aes_issue is high 2 cycles after acceptance.
  - out_valid is high PIPE_LAT+1 cycles after issue, with out_data 69c4e0d86a7b0430d8cdb78070b4c55a and out_tag 0.
- Streaming: 15 blocks on consecutive cycles (each block = previous block XOR 0x01 repeated ×i).
  - 15 consecutive out_valid pulses, tags 0..14, matching known ciphertexts.
  - in_flight peaks at PIPE_LAT+1.
- Full/backpressure: pause=1 while pushing 20 blocks.
  - in_ready drops after count reaches 16.
  - Release pause: exactly 16 outputs, in order, no loss or duplication.
- Bubbles and tag wrap: toggle pause every other cycle over 300 blocks.
  - Outputs appear only for real blocks.
  - out_tag wraps from 255 to 0.
- Key guard: key_load issued while in_flight=5 gives key_err pulse and aes_key unchanged.
  - Retry after drain is accepted: aes_key updates and key_err stays 0.
- Reset mid-stream: reset=0 for one cycle with count=6 and in_flight=8.
  - count, in_flight and aes_issue go to 0; no out_valid for the discarded blocks.
  - A new block afterwards completes with out_tag 0.
